// File: rtl/pipelined_tree_multiplier_if.sv
// Operand/product handshake bundle for pipelined_tree_multiplier.
// The master side provides operands and consumes products.
// The slave side is the multiplier.
//   in_valid/in_ready   : operand handshake; x, y and is_signed travel together
//   out_valid/out_ready : product handshake; o is the 2*WIDTH-bit product
//   occupancy           : number of transactions held in the pipeline (0..3)
interface pipelined_tree_multiplier_if #(
    parameter int WIDTH = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       x;
    logic [WIDTH-1:0]       y;
    logic                   is_signed;
    logic                   out_valid;
    logic                   out_ready;
    logic [2*WIDTH-1:0]     o;
    logic [1:0]             occupancy;

    modport master (
        output in_valid, x, y, is_signed, out_ready,
        input  in_ready, out_valid, o, occupancy
    );

    modport slave (
        input  in_valid, x, y, is_signed, out_ready,
        output in_ready, out_valid, o, occupancy
    );
endinterface

// File: rtl/pipelined_tree_multiplier.sv
// Three-stage pipelined tree multiplier.
// The stages are:
//   S1 latches the partial-product matrix. In signed mode the matrix uses
//      Baugh-Wooley form.
//   S2 reduces the matrix to two rows with a carry-save tree of full adders.
//   S3 resolves the two rows with a parallel-prefix adder.
// A valid/ready handshake runs on both sides, and stalls collapse bubbles.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of pipelined_tree_multiplier_if. It carries:
//            - in_valid, in_ready, x, y, is_signed
//            - out_valid, out_ready, o, occupancy
// Parameters:
//   WIDTH         : operand width, 2..32
//   PREFIX_SPARSE : 0 = full Kogge-Stone final adder
//                   1 = 4-bit-block sparse prefix with ripple inside the blocks
module pipelined_tree_multiplier #(
    parameter int WIDTH         = 4,
    parameter int PREFIX_SPARSE = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    pipelined_tree_multiplier_if.slave bus
);
    localparam int PW   = 2 * WIDTH;        // product width
    localparam int ROWS = WIDTH + 1;        // partial-product rows plus Baugh-Wooley constant row
    localparam int NB   = (PW + 3) / 4;     // 4-bit blocks in the sparse adder
    localparam int PADW = 4 * NB;

    // Baugh-Wooley correction: constant ones at columns WIDTH and 2*WIDTH-1.
    localparam logic [PW-1:0] BW_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] BW_CONST = (BW_ONE << WIDTH) | (BW_ONE << (PW - 1));

    // Number of 3:2 compression levels needed to bring n rows down to two.
    function automatic int csa_levels(input int n);
        int m;
        int lv;
        m  = n;
        lv = 0;
        while (m > 2) begin
            m  = 2 * (m / 3) + (m % 3);
            lv = lv + 1;
        end
        return lv;
    endfunction

    localparam int LEVELS = csa_levels(ROWS);

    // Wallace-style reduction.
    // At each level, every group of three rows becomes a sum row and a
    // shifted carry row. Leftover rows pass straight through to the next level.
    // Carries out of the top column are dropped, which is the intended
    // modulo-2^PW wrap of the Baugh-Wooley constants.
    function automatic logic [2*PW-1:0] csa_reduce(
        input logic [WIDTH-1:0][WIDTH-1:0] pp,
        input logic                        sgn
    );
        logic [PW-1:0] r  [ROWS];
        logic [PW-1:0] nr [ROWS];
        logic [PW-1:0] a;
        logic [PW-1:0] b;
        logic [PW-1:0] c;
        int n;
        int m;
        int idx;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = PW'(pp[i]) << i;
        end
        r[WIDTH] = BW_CONST & {PW{sgn}};
        n = ROWS;
        for (int lv = 0; lv < LEVELS; lv++) begin
            for (int i = 0; i < ROWS; i++) begin
                nr[i] = '0;
            end
            m = 0;
            for (int g = 0; g < ROWS / 3; g++) begin
                if (3 * g + 2 < n) begin
                    a         = r[3*g];
                    b         = r[3*g+1];
                    c         = r[3*g+2];
                    nr[m]     = a ^ b ^ c;
                    nr[m+1]   = ((a & b) | (a & c) | (b & c)) << 1;
                    m         = m + 2;
                end
            end
            for (int k = 0; k < 3; k++) begin
                idx = 3 * (n / 3) + k;
                if (idx < n) begin
                    nr[m] = r[idx];
                    m     = m + 1;
                end
            end
            for (int i = 0; i < ROWS; i++) begin
                r[i] = nr[i];
            end
            n = m;
        end
        return {r[1], r[0]};
    endfunction

    // Kogge-Stone adder.
    // log2(PW) levels of black cells build the (G,P) prefixes.
    // The carry into bit i is the group generate of bits i-1..0.
    function automatic logic [PW-1:0] ks_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PW-1:0] g;
        logic [PW-1:0] p;
        logic [PW-1:0] gg;
        logic [PW-1:0] gp;
        logic [PW-1:0] gn;
        logic [PW-1:0] pn;
        g  = a & b;
        p  = a ^ b;
        gg = g;
        gp = p;
        for (int d = 1; d < PW; d = d * 2) begin
            gn = gg;
            pn = gp;
            for (int i = d; i < PW; i++) begin
                gn[i] = gg[i] | (gp[i] & gg[i-d]);
                pn[i] = gp[i] & gp[i-d];
            end
            gg = gn;
            gp = pn;
        end
        return p ^ {gg[PW-2:0], 1'b0};
    endfunction

    // Sparse prefix adder. It works in three steps:
    //   1. Each 4-bit block forms its group generate/propagate serially.
    //   2. Kogge-Stone runs across the block values only.
    //   3. Each block ripples from its prefix carry.
    // Operands are zero-padded to whole blocks so that no index runs past the top.
    function automatic logic [PW-1:0] sparse_add(input logic [PW-1:0] a, input logic [PW-1:0] b);
        logic [PADW-1:0] g;
        logic [PADW-1:0] p;
        logic [PADW-1:0] s;
        logic [NB-1:0]   bg;
        logic [NB-1:0]   bp;
        logic [NB-1:0]   bgn;
        logic [NB-1:0]   bpn;
        logic [NB-1:0]   cin;
        logic            c;
        g   = PADW'(a) & PADW'(b);
        p   = PADW'(a) ^ PADW'(b);
        s   = '0;
        bg  = '0;
        bp  = '0;
        bgn = '0;
        bpn = '0;
        for (int k = 0; k < NB; k++) begin
            bg[k] = 1'b0;
            bp[k] = 1'b1;
            for (int t = 0; t < 4; t++) begin
                bg[k] = g[4*k+t] | (p[4*k+t] & bg[k]);
                bp[k] = bp[k] & p[4*k+t];
            end
        end
        for (int d = 1; d < NB; d = d * 2) begin
            bgn = bg;
            bpn = bp;
            for (int k = d; k < NB; k++) begin
                bgn[k] = bg[k] | (bp[k] & bg[k-d]);
                bpn[k] = bp[k] & bp[k-d];
            end
            bg = bgn;
            bp = bpn;
        end
        cin = bg << 1;
        for (int k = 0; k < NB; k++) begin
            c = cin[k];
            for (int t = 0; t < 4; t++) begin
                s[4*k+t] = p[4*k+t] ^ c;
                c        = g[4*k+t] | (p[4*k+t] & c);
            end
        end
        return s[PW-1:0];
    endfunction

    logic                        load1_s;
    logic                        load2_s;
    logic                        load3_s;
    logic                        v1_r;
    logic                        v2_r;
    logic                        v3_r;
    logic [WIDTH-1:0][WIDTH-1:0] pp_s;
    logic [WIDTH-1:0][WIDTH-1:0] pp_r1;
    logic                        sgn_r1;
    logic [2*PW-1:0]             red_s;
    logic [PW-1:0]               sum_r2;
    logic [PW-1:0]               carry_r2;
    logic [PW-1:0]               add_s;
    logic [PW-1:0]               o_r;

    // Bubble-collapsing advance: a stage loads when it is empty or when its successor loads.
    assign load3_s = ~v3_r | bus.out_ready;
    assign load2_s = ~v2_r | load3_s;
    assign load1_s = ~v1_r | load2_s;

    // Partial-product matrix.
    // In signed mode, the terms that pair exactly one operand MSB with a
    // non-MSB bit are inverted.
    always_comb begin
        pp_s = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                pp_s[i][j] = (bus.x[j] & bus.y[i]) ^
                             (bus.is_signed & ((i == WIDTH - 1) != (j == WIDTH - 1)));
            end
        end
    end

    assign red_s = csa_reduce(pp_r1, sgn_r1);

    if (PREFIX_SPARSE != 0) begin : g_sparse_adder
        assign add_s = sparse_add(sum_r2, carry_r2);
    end else begin : g_full_adder
        assign add_s = ks_add(sum_r2, carry_r2);
    end

    // Stage valid flags: each one takes its upstream valid whenever the stage loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_r <= 1'b0;
            v2_r <= 1'b0;
            v3_r <= 1'b0;
        end else begin
            if (load1_s) v1_r <= bus.in_valid;
            if (load2_s) v2_r <= v1_r;
            if (load3_s) v3_r <= v2_r;
        end
    end

    // Stage data registers. They hold their value while stalled, so o stays
    // stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pp_r1    <= '0;
            sgn_r1   <= 1'b0;
            sum_r2   <= '0;
            carry_r2 <= '0;
            o_r      <= '0;
        end else begin
            if (load1_s) begin
                pp_r1  <= pp_s;
                sgn_r1 <= bus.is_signed;
            end
            if (load2_s) begin
                sum_r2   <= red_s[PW-1:0];
                carry_r2 <= red_s[2*PW-1:PW];
            end
            if (load3_s) begin
                o_r <= add_s;
            end
        end
    end

    assign bus.in_ready  = load1_s;
    assign bus.out_valid = v3_r;
    assign bus.o         = o_r;
    assign bus.occupancy = {1'b0, v1_r} + {1'b0, v2_r} + {1'b0, v3_r};
endmodule

// File: tb/tb_pipelined_tree_multiplier.sv
// Self-checking bench for pipelined_tree_multiplier.
// It drives two instances:
//   WIDTH=4 with the full prefix adder
//   WIDTH=5 with the sparse prefix adder
// A scoreboard per instance holds expected products. They are pushed on each
// accepted operand pair and popped on each delivered product.
module tb_pipelined_tree_multiplier;
    localparam int WA = 4;
    localparam int WB = 5;

    logic clk = 1'b0;
    logic rst_n;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [63:0] sb_a [$];
    logic [63:0] sb_b [$];

    always #5 clk = ~clk;

    pipelined_tree_multiplier_if #(.WIDTH(WA)) ifa ();
    pipelined_tree_multiplier_if #(.WIDTH(WB)) ifb ();

    pipelined_tree_multiplier #(.WIDTH(WA), .PREFIX_SPARSE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(ifa)
    );
    pipelined_tree_multiplier #(.WIDTH(WB), .PREFIX_SPARSE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ifb)
    );

    task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product, reduced to 2*w bits.
    function automatic logic [63:0] ref_mul(input int w, input logic [31:0] xv,
                                            input logic [31:0] yv, input logic sgn);
        longint a;
        longint b;
        longint p;
        a = longint'(xv);
        b = longint'(yv);
        if (sgn && xv[w-1]) a = a - (longint'(1) << w);
        if (sgn && yv[w-1]) b = b - (longint'(1) << w);
        p = a * b;
        return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    // Scoreboard monitors, sampled on the falling edge while inputs are stable.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ifa.in_valid && ifa.in_ready)
                sb_a.push_back(ref_mul(WA, 32'(ifa.x), 32'(ifa.y), ifa.is_signed));
            if (ifa.out_valid && ifa.out_ready) begin
                if (sb_a.size() == 0) check_value("a_extra_output", 64'(ifa.o), 64'hFFFF_FFFF_FFFF_FFFF);
                else check_value("a_product", 64'(ifa.o), sb_a.pop_front());
            end
            if (ifb.in_valid && ifb.in_ready)
                sb_b.push_back(ref_mul(WB, 32'(ifb.x), 32'(ifb.y), ifb.is_signed));
            if (ifb.out_valid && ifb.out_ready) begin
                if (sb_b.size() == 0) check_value("b_extra_output", 64'(ifb.o), 64'hFFFF_FFFF_FFFF_FFFF);
                else check_value("b_product", 64'(ifb.o), sb_b.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [WA-1:0] xv, input logic [WA-1:0] yv,
                          input logic sv, input bit rnd);
        bit acc;
        acc = 1'b0;
        ifa.x = xv; ifa.y = yv; ifa.is_signed = sv; ifa.in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ifa.in_ready;
            step();
            if (rnd) ifa.out_ready = 1'($urandom_range(0, 1));
        end
        ifa.in_valid = 1'b0;
        if (!acc) check_value("a_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_b(input logic [WB-1:0] xv, input logic [WB-1:0] yv,
                          input logic sv, input bit rnd);
        bit acc;
        acc = 1'b0;
        ifb.x = xv; ifb.y = yv; ifb.is_signed = sv; ifb.in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            acc = ifb.in_ready;
            step();
            if (rnd) ifb.out_ready = 1'($urandom_range(0, 1));
        end
        ifb.in_valid = 1'b0;
        if (!acc) check_value("b_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic drain_a();
        ifa.in_valid = 1'b0;
        ifa.out_ready = 1'b1;
        for (int t = 0; t < 20 && ifa.occupancy != 2'd0; t++) step();
        check_value("a_drain_occupancy", 64'(ifa.occupancy), 64'd0);
        check_value("a_drain_queue", 64'(sb_a.size()), 64'd0);
    endtask

    task automatic drain_b();
        ifb.in_valid = 1'b0;
        ifb.out_ready = 1'b1;
        for (int t = 0; t < 20 && ifb.occupancy != 2'd0; t++) step();
        check_value("b_drain_occupancy", 64'(ifb.occupancy), 64'd0);
        check_value("b_drain_queue", 64'(sb_b.size()), 64'd0);
    endtask

    // Watchdog against a hung handshake.
    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Directed scenarios followed by exhaustive sweeps under random backpressure.
    initial begin
        logic [WA-1:0] t2_x   [4] = '{4'h8, 4'h8, 4'h7, 4'h8};
        logic [WA-1:0] t2_y   [4] = '{4'h8, 4'h7, 4'hF, 4'h8};
        logic          t2_s   [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [7:0]    t2_exp [4] = '{8'h40, 8'hC8, 8'hF9, 8'h40};

        ifa.in_valid = 1'b0; ifa.x = '0; ifa.y = '0; ifa.is_signed = 1'b0; ifa.out_ready = 1'b0;
        ifb.in_valid = 1'b0; ifb.x = '0; ifb.y = '0; ifb.is_signed = 1'b0; ifb.out_ready = 1'b0;
        rst_n = 1'b0;
        #12;
        check_value("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        check_value("rst_o", 64'(ifa.o), 64'd0);
        check_value("rst_occupancy", 64'(ifa.occupancy), 64'd0);
        check_value("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        check_value("rst_b_in_ready", 64'(ifb.in_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // 15*15 unsigned: latency and occupancy.
        ifa.out_ready = 1'b1;
        ifa.x = 4'hF; ifa.y = 4'hF; ifa.is_signed = 1'b0; ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        @(negedge clk);
        check_value("t1_occ_after_accept", 64'(ifa.occupancy), 64'd1);
        check_value("t1_valid_edge1", 64'(ifa.out_valid), 64'd0);
        @(negedge clk);
        check_value("t1_valid_edge2", 64'(ifa.out_valid), 64'd0);
        @(negedge clk);
        check_value("t1_valid_edge3", 64'(ifa.out_valid), 64'd1);
        check_value("t1_product", 64'(ifa.o), 64'hE1);
        @(negedge clk);
        check_value("t1_valid_after", 64'(ifa.out_valid), 64'd0);
        check_value("t1_occ_after", 64'(ifa.occupancy), 64'd0);
        step();

        // Back-to-back mixed signed/unsigned.
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) begin
                ifa.x = t2_x[i]; ifa.y = t2_y[i]; ifa.is_signed = t2_s[i]; ifa.in_valid = 1'b1;
            end else begin
                ifa.in_valid = 1'b0;
            end
            @(negedge clk);
            if (i >= 3) begin
                check_value("t2_valid", 64'(ifa.out_valid), 64'd1);
                check_value("t2_product", 64'(ifa.o), 64'(t2_exp[i-3]));
            end
            step();
        end
        drain_a();

        // Backpressure: fill all three stages, then release.
        ifa.out_ready = 1'b0;
        ifa.is_signed = 1'b0;
        ifa.in_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            ifa.x = 4'(k); ifa.y = 4'(k);
            step();
        end
        ifa.x = 4'd4; ifa.y = 4'd4;
        repeat (2) begin
            @(negedge clk);
            check_value("t3_in_ready_full", 64'(ifa.in_ready), 64'd0);
            check_value("t3_occ_full", 64'(ifa.occupancy), 64'd3);
            check_value("t3_valid_held", 64'(ifa.out_valid), 64'd1);
            check_value("t3_o_held", 64'(ifa.o), 64'd1);
        end
        step();
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("t3_valid_stream", 64'(ifa.out_valid), 64'd1);
            check_value("t3_product", 64'(ifa.o), 64'((i + 1) * (i + 1)));
            step();
            if (i == 0) begin ifa.x = 4'd5; ifa.y = 4'd5; end
            if (i == 1) ifa.in_valid = 1'b0;
        end
        drain_a();

        // Bubble collapse behind a stalled output.
        ifa.out_ready = 1'b0;
        ifa.x = 4'd3; ifa.y = 4'd5; ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        step();
        ifa.x = 4'd6; ifa.y = 4'd7; ifa.in_valid = 1'b1;
        step();
        ifa.in_valid = 1'b0;
        step();
        @(negedge clk);
        check_value("t4_occupancy", 64'(ifa.occupancy), 64'd2);
        check_value("t4_valid", 64'(ifa.out_valid), 64'd1);
        check_value("t4_o_head", 64'(ifa.o), 64'd15);
        check_value("t4_in_ready", 64'(ifa.in_ready), 64'd1);
        step();
        drain_a();

        // Asynchronous reset with three items in flight.
        ifa.out_ready = 1'b0;
        ifa.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ifa.x = 4'(k + 9); ifa.y = 4'(k + 2);
            step();
        end
        ifa.in_valid = 1'b0;
        @(negedge clk);
        check_value("t5_occ_before", 64'(ifa.occupancy), 64'd3);
        #2 rst_n = 1'b0;
        #1;
        check_value("t5_valid_in_reset", 64'(ifa.out_valid), 64'd0);
        check_value("t5_o_in_reset", 64'(ifa.o), 64'd0);
        check_value("t5_occ_in_reset", 64'(ifa.occupancy), 64'd0);
        check_value("t5_in_ready_in_reset", 64'(ifa.in_ready), 64'd1);
        sb_a.delete();
        sb_b.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_value("t5_no_stale_valid", 64'(ifa.out_valid), 64'd0);
        end
        step();

        // Exhaustive sweeps with random out_ready.
        for (int s = 0; s < 2; s++)
            for (int xi = 0; xi < (1 << WA); xi++)
                for (int yi = 0; yi < (1 << WA); yi++)
                    send_a(WA'(xi), WA'(yi), 1'(s), 1'b1);
        drain_a();
        for (int s = 0; s < 2; s++)
            for (int xi = 0; xi < (1 << WB); xi++)
                for (int yi = 0; yi < (1 << WB); yi++)
                    send_b(WB'(xi), WB'(yi), 1'(s), 1'b1);
        drain_b();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
